// File: rtl/tdc_pkg.sv
// Shared types and helpers for the multichannel TDC.
// Default geometry, widths, entry layout, state enum.
package tdc_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_RUN
  } state_t;

  localparam int CHANNELS_D   = 4;
  localparam int TAPS_D       = 32;
  localparam int COARSE_W_D   = 12;
  localparam int FIFO_DEPTH_D = 8;

  function automatic int ch_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int fine_width(input int taps);
    return $clog2(taps + 1);
  endfunction

  localparam int CH_W_D   = ch_width(CHANNELS_D);
  localparam int FINE_W_D = fine_width(TAPS_D);
  localparam int ENTRY_W_D = CH_W_D + COARSE_W_D + FINE_W_D;

  typedef struct packed {
    logic [CH_W_D-1:0]     channel;
    logic [COARSE_W_D-1:0] coarse;
    logic [FINE_W_D-1:0]   fine;
  } entry_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/tdc_multichannel_core_if.sv
// Timestamp output stream of the TDC core.
// Master drives valid/data, slave drives ready.
interface tdc_multichannel_core_if
  import tdc_pkg::*;
#(
  parameter int W = ENTRY_W_D
) ();
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;

  modport master (
    output out_valid,
    output out_data,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    output out_ready
  );
endinterface

// File: rtl/tdc_sync_fifo.sv
// Single-clock FIFO, async active-high reset.
// Push while full is accepted when a pop happens in the same cycle.
module tdc_sync_fifo #(
  parameter int W     = 20,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr;
  logic [AW:0]  r_rd;
  logic         w_wr;
  logic         w_rd;

  assign o_empty = (r_wr == r_rd);
  assign o_full  = (r_wr[AW] != r_rd[AW]) &&
                   (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign o_data  = r_mem[r_rd[AW-1:0]];
  assign w_rd    = i_pop && !o_empty;
  assign w_wr    = i_push && (!o_full || w_rd);

  // storage write, no reset needed on the data array
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr[AW-1:0]] <= i_data;
  end

  // read/write pointers with wrap bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_wr) r_wr <= r_wr + 1'b1;
      if (w_rd) r_rd <= r_rd + 1'b1;
    end
  end
endmodule

// File: rtl/tdc_multichannel_core.sv
// Multichannel TDC: edge capture, popcount fine encode,
// fixed-priority merge of all channels into one FIFO.
module tdc_multichannel_core
  import tdc_pkg::*;
#(
  parameter int CHANNELS   = CHANNELS_D,
  parameter int TAPS       = TAPS_D,
  parameter int COARSE_W   = COARSE_W_D,
  parameter int FIFO_DEPTH = FIFO_DEPTH_D,
  localparam int CH_W      = ch_width(CHANNELS),
  localparam int FINE_W    = fine_width(TAPS),
  localparam int DW        = CH_W + COARSE_W + FINE_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_mode,
  input  logic                     i_arm,
  input  logic                     i_start,
  input  logic                     i_stop,
  input  logic [CHANNELS-1:0]      i_hit,
  input  logic [CHANNELS*TAPS-1:0] i_therm,
  tdc_multichannel_core_if.master  o_out,
  output logic                     o_busy,
  output logic                     o_overflow,
  output logic [7:0]               o_drop_count
);
  state_t               r_state, w_state_nxt;
  logic                 r_mode;
  logic [COARSE_W-1:0]  r_coarse;
  logic [CHANNELS-1:0]  r_hit_q, r_cap_vld, r_pend, r_done;
  logic [TAPS-1:0]      r_cap_therm [CHANNELS];
  logic [COARSE_W-1:0]  r_cap_coarse [CHANNELS];
  logic [COARSE_W-1:0]  r_pend_coarse [CHANNELS];
  logic [FINE_W-1:0]    r_pend_fine [CHANNELS];
  logic                 r_overflow;
  logic [7:0]           r_drop;

  logic [FINE_W-1:0]    w_fine [CHANNELS];
  logic [CHANNELS-1:0]  w_take, w_cap, w_drop, w_clr;
  logic [CH_W-1:0]      w_sel;
  logic                 w_sel_vld, w_push, w_pop;
  logic                 w_full, w_empty, w_ovf_set;
  logic                 w_arm_acc, w_start_acc;
  logic [7:0]           w_drop_nxt;
  logic [DW-1:0]        w_head, w_push_data;

  assign w_arm_acc   = (r_state == S_IDLE) && i_arm && !i_stop;
  assign w_start_acc = (r_state == S_ARMED) && i_start && !i_stop;

  // a channel ignores edges once done in single-shot mode
  assign w_take = i_hit & ~r_hit_q
                & {CHANNELS{r_state == S_RUN}}
                & ~(r_mode ? '0 : r_done);
  assign w_cap  = w_take & ~(r_cap_vld | r_pend);
  assign w_drop = w_take & (r_cap_vld | r_pend);

  assign w_pop  = o_out.out_valid && o_out.out_ready;
  assign w_push = w_sel_vld && (!w_full || w_pop);
  assign w_push_data = {w_sel, r_pend_coarse[w_sel],
                        r_pend_fine[w_sel]};

  assign o_out.out_valid = !w_empty;
  assign o_out.out_data  = w_empty ? '0 : w_head;
  assign o_busy          = (r_state != S_IDLE);
  assign o_overflow      = r_overflow;
  assign o_drop_count    = r_drop;

  // bubble-tolerant fine code: count of set taps
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      w_fine[i] = '0;
      for (int j = 0; j < TAPS; j++)
        w_fine[i] = w_fine[i] + FINE_W'(r_cap_therm[i][j]);
    end
  end

  // lowest pending channel wins the single push slot
  always_comb begin
    w_sel_vld = 1'b0;
    w_sel     = '0;
    w_clr     = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (r_pend[i]) begin
        w_sel_vld = 1'b1;
        w_sel     = CH_W'(i);
      end
    end
    if (w_push) w_clr[w_sel] = 1'b1;
  end

  // lost hits counted individually, saturating
  always_comb begin
    w_drop_nxt = r_drop;
    for (int i = 0; i < CHANNELS; i++)
      if (w_drop[i]) w_drop_nxt = sat_inc(w_drop_nxt);
  end

  // run control: stop wins, overflow then completion end a single-shot run
  always_comb begin
    w_state_nxt = r_state;
    w_ovf_set   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_arm_acc) w_state_nxt = S_ARMED;
      end
      S_ARMED: begin
        if (i_stop) w_state_nxt = S_IDLE;
        else if (i_start) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (i_stop) begin
          w_state_nxt = S_IDLE;
        end else if (!r_mode && (&r_coarse)) begin
          w_state_nxt = S_IDLE;
          w_ovf_set   = 1'b1;
        end else if (!r_mode && (&r_done) &&
                     !(|(r_cap_vld | r_pend))) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // state, coarse counter and run-level flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_mode     <= 1'b0;
      r_coarse   <= '0;
      r_done     <= '0;
      r_overflow <= 1'b0;
      r_drop     <= '0;
      r_hit_q    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_hit_q <= i_hit;
      if (r_state == S_IDLE) r_mode <= i_mode;
      if (w_start_acc) r_coarse <= '0;
      else if (r_state == S_RUN) r_coarse <= r_coarse + 1'b1;
      if (w_start_acc) r_done <= '0;
      else r_done <= r_done | w_cap;
      if (w_arm_acc) r_overflow <= 1'b0;
      else if (w_ovf_set) r_overflow <= 1'b1;
      if (w_arm_acc) r_drop <= '0;
      else r_drop <= w_drop_nxt;
    end
  end

  // capture stage then encoded pending stage per channel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cap_vld <= '0;
      r_pend    <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        r_cap_therm[i]   <= '0;
        r_cap_coarse[i]  <= '0;
        r_pend_coarse[i] <= '0;
        r_pend_fine[i]   <= '0;
      end
    end else begin
      r_cap_vld <= w_cap;
      r_pend    <= (r_pend & ~w_clr) | r_cap_vld;
      for (int i = 0; i < CHANNELS; i++) begin
        if (w_cap[i]) begin
          r_cap_therm[i]  <= i_therm[i*TAPS +: TAPS];
          r_cap_coarse[i] <= r_coarse;
        end
        if (r_cap_vld[i]) begin
          r_pend_coarse[i] <= r_cap_coarse[i];
          r_pend_fine[i]   <= w_fine[i];
        end
      end
    end
  end

  tdc_sync_fifo #(
    .W     (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );
endmodule

// File: tb/tb_tdc_multichannel_core.sv
// Self-checking bench for tdc_multichannel_core.
// Scoreboard queue plus table vectors and corner sequences.
module tb_tdc_multichannel_core;
  import tdc_pkg::*;

  logic         clk;
  logic         rst;
  logic         i_mode, i_arm, i_start, i_stop;
  logic [3:0]   i_hit;
  logic [127:0] i_therm;
  logic         o_busy, o_overflow;
  logic [7:0]   o_drop_count;

  tdc_multichannel_core_if #(.W(ENTRY_W_D)) u_if ();

  tdc_multichannel_core u_dut (
    .clk          (clk),
    .rst          (rst),
    .i_mode       (i_mode),
    .i_arm        (i_arm),
    .i_start      (i_start),
    .i_stop       (i_stop),
    .i_hit        (i_hit),
    .i_therm      (i_therm),
    .o_out        (u_if),
    .o_busy       (o_busy),
    .o_overflow   (o_overflow),
    .o_drop_count (o_drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     n_checks = 0;
  int     n_fail   = 0;
  int     cyc      = 0;
  int     start_cyc = 0;
  entry_t sb[$];

  typedef struct {
    int          ch;
    logic [31:0] th;
    int          fine;
  } vec_t;
  vec_t vecs[7];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic entry_t mk(input int ch, input int co,
                                input int fi);
    entry_t e;
    e.channel = CH_W_D'(ch);
    e.coarse  = COARSE_W_D'(co);
    e.fine    = FINE_W_D'(fi);
    return e;
  endfunction

  function automatic int exp_coarse();
    return (cyc - start_cyc - 1) % 4096;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) tick();
  endtask

  task automatic run_begin(input logic m);
    i_mode = m;
    i_arm  = 1'b1;
    tick();
    i_arm   = 1'b0;
    i_start = 1'b1;
    start_cyc = cyc;
    tick();
    i_start = 1'b0;
  endtask

  task automatic do_stop();
    i_stop = 1'b1;
    tick();
    i_stop = 1'b0;
  endtask

  task automatic pulse(input logic [3:0] m);
    i_hit = m;
    tick();
    i_hit = '0;
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check(name, 32'(sb.size()), 32'd0);
  endtask

  // scoreboard monitor samples mid-cycle
  always @(negedge clk) begin
    if (!rst && u_if.out_valid && u_if.out_ready) begin
      if (sb.size() == 0) begin
        check("sb_unexpected", 32'(u_if.out_data), 32'hFFFFFFFF);
      end else begin
        check("sb_data", 32'(u_if.out_data), 32'(sb.pop_front()));
      end
    end
  end

  initial begin
    vecs[0] = '{0, 32'h000000F7, 7};
    vecs[1] = '{0, 32'hFFFFFFFF, 32};
    vecs[2] = '{0, 32'h00000000, 0};
    vecs[3] = '{1, 32'h0000FFFF, 16};
    vecs[4] = '{3, 32'h80000001, 2};
    vecs[5] = '{2, 32'h55555555, 16};
    vecs[6] = '{1, 32'h00000001, 1};

    rst = 1'b1;
    i_mode = 0; i_arm = 0; i_start = 0; i_stop = 0;
    i_hit = '0; i_therm = '0;
    u_if.out_ready = 1'b1;
    #1;
    check("rst_valid", 32'(u_if.out_valid), 0);
    check("rst_data", 32'(u_if.out_data), 0);
    check("rst_busy", 32'(o_busy), 0);
    check("rst_ovf", 32'(o_overflow), 0);
    check("rst_drop", 32'(o_drop_count), 0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // single-shot: ch2 at cycle 11, then the rest at cycle 20
    run_begin(1'b0);
    wait_until(start_cyc + 11);
    i_therm[2*32 +: 32] = 32'h000000FF;
    sb.push_back(mk(2, exp_coarse(), 8));
    pulse(4'b0100);
    tick();
    check("ss_valid_early", 32'(u_if.out_valid), 0);
    tick();
    check("ss_valid_t3", 32'(u_if.out_valid), 1);
    check("ss_data", 32'(u_if.out_data), 32'(mk(2, 10, 8)));
    wait_until(start_cyc + 20);
    i_therm[0*32 +: 32] = 32'h00000001;
    i_therm[1*32 +: 32] = 32'h00000003;
    i_therm[3*32 +: 32] = 32'h00000007;
    sb.push_back(mk(0, exp_coarse(), 1));
    sb.push_back(mk(1, exp_coarse(), 2));
    sb.push_back(mk(3, exp_coarse(), 3));
    pulse(4'b1111);
    begin
      int n = 0;
      while (o_busy && n < 30) begin tick(); n++; end
    end
    check("ss_done_busy", 32'(o_busy), 0);
    check("ss_drop", 32'(o_drop_count), 0);
    drain("ss_drain", 20);

    // table vectors in continuous mode
    run_begin(1'b1);
    for (int k = 0; k < 7; k++) begin
      tick(); tick(); tick();
      i_therm[vecs[k].ch*32 +: 32] = vecs[k].th;
      sb.push_back(mk(vecs[k].ch, exp_coarse(), vecs[k].fine));
      pulse(4'(1 << vecs[k].ch));
    end
    drain("vec_drain", 20);
    check("vec_busy", 32'(o_busy), 1);
    do_stop();

    // simultaneous edges on ch0 and ch3 at cycle 5
    run_begin(1'b1);
    wait_until(start_cyc + 5);
    i_therm[0*32 +: 32] = 32'h0000000F;
    i_therm[3*32 +: 32] = 32'h0003FFFF;
    sb.push_back(mk(0, 4, 4));
    sb.push_back(mk(3, 4, 18));
    pulse(4'b1001);
    tick();
    check("sim_v0", 32'(u_if.out_valid), 0);
    tick();
    check("sim_v1", 32'(u_if.out_valid), 1);
    tick();
    check("sim_v2", 32'(u_if.out_valid), 1);
    tick();
    check("sim_v3", 32'(u_if.out_valid), 0);
    check("sim_drop", 32'(o_drop_count), 0);
    drain("sim_drain", 5);
    do_stop();

    // backpressure: 10 hits on ch1, fifo holds 8, one pending, one lost
    run_begin(1'b1);
    u_if.out_ready = 1'b0;
    i_therm[1*32 +: 32] = 32'h000003FF;
    for (int k = 0; k < 10; k++) begin
      tick(); tick(); tick();
      if (k < 9) sb.push_back(mk(1, exp_coarse(), 10));
      pulse(4'b0010);
    end
    tick(); tick(); tick(); tick();
    check("bp_drop", 32'(o_drop_count), 1);
    check("bp_valid", 32'(u_if.out_valid), 1);
    check("bp_head", 32'(u_if.out_data), 32'(sb[0]));
    tick(); tick(); tick();
    check("bp_stable", 32'(u_if.out_data), 32'(sb[0]));
    u_if.out_ready = 1'b1;
    drain("bp_drain", 40);
    tick();
    check("bp_empty", 32'(u_if.out_valid), 0);
    do_stop();

    // single-shot overflow with no hits
    run_begin(1'b0);
    wait_until(start_cyc + 4096);
    check("ovf_busy_last", 32'(o_busy), 1);
    check("ovf_flag_pre", 32'(o_overflow), 0);
    tick();
    check("ovf_busy", 32'(o_busy), 0);
    check("ovf_flag", 32'(o_overflow), 1);
    check("ovf_valid", 32'(u_if.out_valid), 0);
    i_arm = 1'b1;
    tick();
    i_arm = 1'b0;
    check("ovf_arm_clr", 32'(o_overflow), 0);
    check("ovf_armed", 32'(o_busy), 1);
    do_stop();

    // reset in the middle of a run with queued entries
    run_begin(1'b1);
    u_if.out_ready = 1'b0;
    tick(); tick();
    pulse(4'b0001);
    tick();
    pulse(4'b0001);
    tick(); tick(); tick();
    pulse(4'b0010);
    tick(); tick(); tick();
    pulse(4'b0100);
    tick(); tick(); tick(); tick(); tick();
    check("mr_drop_pre", 32'(o_drop_count), 1);
    check("mr_valid_pre", 32'(u_if.out_valid), 1);
    sb.delete();
    #2;
    rst = 1'b1;
    #1;
    check("mr_valid_async", 32'(u_if.out_valid), 0);
    check("mr_busy_async", 32'(o_busy), 0);
    check("mr_data_async", 32'(u_if.out_data), 0);
    tick(); tick();
    rst = 1'b0;
    tick(); tick();
    check("mr_valid_post", 32'(u_if.out_valid), 0);
    check("mr_drop_post", 32'(o_drop_count), 0);
    check("mr_busy_post", 32'(o_busy), 0);
    u_if.out_ready = 1'b1;
    tick(); tick();
    check("sb_leftover", 32'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule
